// File: rtl/fetch_sequencer.sv
// Program-counter / instruction-fetch sequencer with one level of interrupt and PC/flags save-restore.
// Optional build macro IRQ_WAKE_EN: an irq may wake the core from HALTED when no ISR is active.
module fetch_sequencer #(
    parameter int                  ADDR_W    = 8,
    parameter logic [ADDR_W-1:0]   RESET_VEC = 8'h00,
    parameter logic [ADDR_W-1:0]   ISR_VEC   = 8'hF0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              im_rdy,
    input  logic              halt,
    input  logic              jmp,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic              rti,
    input  logic              irq,
    input  logic [3:0]        flags_in,
    output logic [ADDR_W-1:0] im_addr,
    output logic              irq_ack,
    output logic              in_isr,
    output logic              halted,
    output logic [3:0]        saved_flags,
    output logic              flags_restore
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_ISR    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_saved_pc;
    logic [3:0]        r_saved_flags;
    logic              r_irq_ack;
    logic              r_flags_restore;
    logic              r_in_isr;
    logic              r_halted;

    state_t            w_state_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_saved_pc_nxt;
    logic [3:0]        w_saved_flags_nxt;
    logic              w_irq_ack_nxt;
    logic              w_flags_restore_nxt;
    logic              w_in_isr_nxt;
    logic              w_halted_nxt;
    logic [ADDR_W-1:0] w_seq_pc;
    logic [ADDR_W-1:0] w_next_pc;

    // Sequential successor; ADDR_W-bit add so the all-ones address wraps to zero.
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(1);
    endfunction

    // Fetch address that the current instruction hands on to the next step.
    always_comb begin
        w_seq_pc  = pc_inc(r_pc);
        w_next_pc = w_seq_pc;
        if (jmp) begin
            w_next_pc = jmp_target;
        end else begin
            w_next_pc = w_seq_pc;
        end
    end

    // Next-state, next-PC and save/restore decisions for one step.
    always_comb begin
        w_state_nxt         = r_state;
        w_pc_nxt            = r_pc;
        w_saved_pc_nxt      = r_saved_pc;
        w_saved_flags_nxt   = r_saved_flags;
        w_irq_ack_nxt       = 1'b0;
        w_flags_restore_nxt = 1'b0;
        w_in_isr_nxt        = r_in_isr;
        w_halted_nxt        = r_halted;

        if (im_rdy) begin
            case (r_state)
                ST_RUN: begin
                    // halt outranks irq; a simultaneous irq is simply not taken this step
                    if (halt) begin
                        w_state_nxt  = ST_HALTED;
                        w_halted_nxt = 1'b1;
                    end else if (irq) begin
                        w_saved_pc_nxt    = w_next_pc;
                        w_saved_flags_nxt = flags_in;
                        w_pc_nxt          = ISR_VEC;
                        w_irq_ack_nxt     = 1'b1;
                        w_in_isr_nxt      = 1'b1;
                        w_state_nxt       = ST_ISR;
                    end else begin
                        w_pc_nxt = w_next_pc;
                    end
                end
                ST_ISR: begin
                    if (halt) begin
                        w_state_nxt  = ST_HALTED;
                        w_halted_nxt = 1'b1;
                    end else if (rti) begin
                        w_pc_nxt            = r_saved_pc;
                        w_flags_restore_nxt = 1'b1;
                        w_in_isr_nxt        = 1'b0;
                        w_state_nxt         = ST_RUN;
                    end else begin
                        w_pc_nxt = w_next_pc;
                    end
                end
                ST_HALTED: begin
`ifdef IRQ_WAKE_EN
                    // A halt taken inside the ISR is terminal; only a RUN-level halt may wake.
                    if (irq && !r_in_isr) begin
                        w_saved_pc_nxt    = w_seq_pc;
                        w_saved_flags_nxt = flags_in;
                        w_pc_nxt          = ISR_VEC;
                        w_irq_ack_nxt     = 1'b1;
                        w_in_isr_nxt      = 1'b1;
                        w_halted_nxt      = 1'b0;
                        w_state_nxt       = ST_ISR;
                    end else begin
                        w_state_nxt = ST_HALTED;
                    end
`else
                    w_state_nxt = ST_HALTED;
`endif
                end
                default: begin
                    w_state_nxt  = ST_RUN;
                    w_pc_nxt     = RESET_VEC;
                    w_in_isr_nxt = 1'b0;
                    w_halted_nxt = 1'b0;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // State, PC and save registers; pulses are registered so they land one cycle after the step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_RUN;
            r_pc            <= RESET_VEC;
            r_saved_pc      <= '0;
            r_saved_flags   <= 4'b0000;
            r_irq_ack       <= 1'b0;
            r_flags_restore <= 1'b0;
            r_in_isr        <= 1'b0;
            r_halted        <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_pc            <= w_pc_nxt;
            r_saved_pc      <= w_saved_pc_nxt;
            r_saved_flags   <= w_saved_flags_nxt;
            r_irq_ack       <= w_irq_ack_nxt;
            r_flags_restore <= w_flags_restore_nxt;
            r_in_isr        <= w_in_isr_nxt;
            r_halted        <= w_halted_nxt;
        end
    end

    assign im_addr       = r_pc;
    assign irq_ack       = r_irq_ack;
    assign in_isr        = r_in_isr;
    assign halted        = r_halted;
    assign saved_flags   = r_saved_flags;
    assign flags_restore = r_flags_restore;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer (RESET_VEC=0x00, ISR_VEC=0xF0).
module tb_fetch_sequencer;

    logic       clk;
    logic       rst;
    logic       im_rdy;
    logic       halt;
    logic       jmp;
    logic [7:0] jmp_target;
    logic       rti;
    logic       irq;
    logic [3:0] flags_in;
    logic [7:0] im_addr;
    logic       irq_ack;
    logic       in_isr;
    logic       halted;
    logic [3:0] saved_flags;
    logic       flags_restore;

    int checks;
    int errors;

    fetch_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .im_rdy        (im_rdy),
        .halt          (halt),
        .jmp           (jmp),
        .jmp_target    (jmp_target),
        .rti           (rti),
        .irq           (irq),
        .flags_in      (flags_in),
        .im_addr       (im_addr),
        .irq_ack       (irq_ack),
        .in_isr        (in_isr),
        .halted        (halted),
        .saved_flags   (saved_flags),
        .flags_restore (flags_restore)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic jump_to(input logic [7:0] tgt);
        jmp        = 1'b1;
        jmp_target = tgt;
        tick();
        jmp        = 1'b0;
        jmp_target = 8'h00;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        im_rdy     = 1'b0;
        halt       = 1'b0;
        jmp        = 1'b0;
        jmp_target = 8'h00;
        rti        = 1'b0;
        irq        = 1'b0;
        flags_in   = 4'b0000;
        #3;
        chk("rst_addr", im_addr, 8'h00);
        chk("rst_ack", {7'd0, irq_ack}, 8'h00);
        chk("rst_isr", {7'd0, in_isr}, 8'h00);
        chk("rst_halted", {7'd0, halted}, 8'h00);
        chk("rst_sflags", {4'd0, saved_flags}, 8'h00);
        tick();
        rst    = 1'b0;
        im_rdy = 1'b1;

        tick();
        chk("seq_inc", im_addr, 8'h01);

        // irq with same-cycle jmp: saved return address is the jump target
        jump_to(8'h10);
        chk("jmp_10", im_addr, 8'h10);
        jmp = 1'b1; jmp_target = 8'h40; irq = 1'b1; flags_in = 4'b1010;
        tick();
        jmp = 1'b0; jmp_target = 8'h00; irq = 1'b0; flags_in = 4'b0000;
        chk("irq_addr", im_addr, 8'hF0);
        chk("irq_ack", {7'd0, irq_ack}, 8'h01);
        chk("irq_isr", {7'd0, in_isr}, 8'h01);
        chk("irq_sflags", {4'd0, saved_flags}, 8'h0A);
        tick();
        chk("isr_step", im_addr, 8'hF1);
        chk("ack_one_cycle", {7'd0, irq_ack}, 8'h00);

        // no nesting while in the ISR
        irq = 1'b1; flags_in = 4'b0101;
        tick();
        chk("nest_ack0", {7'd0, irq_ack}, 8'h00);
        chk("nest_addr0", im_addr, 8'hF2);
        irq = 1'b0;
        tick();
        irq = 1'b1;
        tick();
        chk("nest_ack1", {7'd0, irq_ack}, 8'h00);
        chk("nest_addr1", im_addr, 8'hF4);
        chk("nest_sflags", {4'd0, saved_flags}, 8'h0A);

        // rti with irq still high: one instruction at 0x40, then re-entry
        rti = 1'b1;
        tick();
        rti = 1'b0;
        chk("rti_addr", im_addr, 8'h40);
        chk("rti_restore", {7'd0, flags_restore}, 8'h01);
        chk("rti_sflags", {4'd0, saved_flags}, 8'h0A);
        chk("rti_isr", {7'd0, in_isr}, 8'h00);
        tick();
        irq = 1'b0; flags_in = 4'b0000;
        chk("reent_addr", im_addr, 8'hF0);
        chk("reent_ack", {7'd0, irq_ack}, 8'h01);
        chk("reent_restore", {7'd0, flags_restore}, 8'h00);
        chk("reent_sflags", {4'd0, saved_flags}, 8'h05);
        rti = 1'b1;
        tick();
        rti = 1'b0;
        chk("rti2_addr", im_addr, 8'h41);
        chk("rti2_restore", {7'd0, flags_restore}, 8'h01);

        // asynchronous reset mid-run at 0x05
        jump_to(8'h05);
        chk("pre_rst_addr", im_addr, 8'h05);
        #2 rst = 1'b1;
        #1;
        chk("arst_addr", im_addr, 8'h00);
        chk("arst_halted", {7'd0, halted}, 8'h00);
        chk("arst_isr", {7'd0, in_isr}, 8'h00);
        chk("arst_sflags", {4'd0, saved_flags}, 8'h00);
        #1 rst = 1'b0;

        // rti outside the ISR is a plain step
        jump_to(8'h30);
        rti = 1'b1;
        tick();
        rti = 1'b0;
        chk("rti_run_addr", im_addr, 8'h31);
        chk("rti_run_restore", {7'd0, flags_restore}, 8'h00);

        // wrap and wait states
        jump_to(8'hFF);
        tick();
        chk("wrap", im_addr, 8'h00);
        jump_to(8'h20);
        im_rdy = 1'b0; irq = 1'b1; rti = 1'b1; jmp = 1'b1; jmp_target = 8'h77;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_addr", im_addr, 8'h20);
            chk("wait_ack", {7'd0, irq_ack}, 8'h00);
            chk("wait_restore", {7'd0, flags_restore}, 8'h00);
        end
        im_rdy = 1'b1; irq = 1'b0; rti = 1'b0; jmp = 1'b0; jmp_target = 8'h00;
        tick();
        chk("wait_resume", im_addr, 8'h21);

        // halt beats a simultaneous irq
        jump_to(8'h08);
        halt = 1'b1; irq = 1'b1;
        tick();
        halt = 1'b0; irq = 1'b0;
        chk("halt_flag", {7'd0, halted}, 8'h01);
        chk("halt_addr", im_addr, 8'h08);
        chk("halt_noack", {7'd0, irq_ack}, 8'h00);
        tick();
        chk("halt_hold", im_addr, 8'h08);
        irq = 1'b1; flags_in = 4'b0011;
        tick();
        irq = 1'b0; flags_in = 4'b0000;
`ifdef IRQ_WAKE_EN
        chk("wake_addr", im_addr, 8'hF0);
        chk("wake_ack", {7'd0, irq_ack}, 8'h01);
        chk("wake_halted", {7'd0, halted}, 8'h00);
        chk("wake_sflags", {4'd0, saved_flags}, 8'h03);
        rti = 1'b1;
        tick();
        rti = 1'b0;
        chk("wake_ret", im_addr, 8'h09);
`else
        chk("nowake_addr", im_addr, 8'h08);
        chk("nowake_halted", {7'd0, halted}, 8'h01);
        chk("nowake_ack", {7'd0, irq_ack}, 8'h00);
`endif
        rst = 1'b1;
        #1;
        chk("rst_unhalt", {7'd0, halted}, 8'h00);
        rst = 1'b0;

        // halt taken inside the ISR keeps in_isr and cannot be woken
        irq = 1'b1;
        tick();
        irq = 1'b0;
        chk("isr2_entry", im_addr, 8'hF0);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("isr_halt", {7'd0, halted}, 8'h01);
        chk("isr_halt_isr", {7'd0, in_isr}, 8'h01);
        irq = 1'b1;
        tick();
        tick();
        irq = 1'b0;
        chk("isr_halt_stuck", {7'd0, halted}, 8'h01);
        chk("isr_halt_noack", {7'd0, irq_ack}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
